// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory and the decode stage.
// Decode handshake: instr_valid is the IF/ID valid, stall is the inverse of decode ready;
// an instruction is consumed on a rising edge where instr_valid=1 and stall=0.
interface fetch_stage_if #(
  parameter int n = 16,
  parameter int r = 5
);
  logic         stall;
  logic         redirect_valid;
  logic [r-1:0] redirect_pc;
  logic [r-1:0] imem_addr;
  logic [n-1:0] imem_readdata;
  logic [n-1:0] instr;
  logic [r-1:0] instr_pc;
  logic         instr_valid;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  imem_readdata,
    output imem_addr,
    output instr,
    output instr_pc,
    output instr_valid
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_pc,
    output imem_readdata,
    input  imem_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the combinational imem port and
// fills the IF/ID register; stops on the halt word until a redirect.
module fetch_stage #(
  parameter int           n         = 16,
  parameter int           r         = 5,
  parameter logic [n-1:0] HALT_WORD = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus,
  output logic          halted,
  output logic [15:0]   fetch_count,
  output logic          dbg_state
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [r-1:0] PC_STEP   = {{(r-1){1'b0}}, 1'b1};
  localparam logic [15:0]  COUNT_MAX = 16'hFFFF;

  state_t       state_q, state_d;
  logic [r-1:0] pc_q, pc_d;
  logic [n-1:0] instr_q, instr_d;
  logic [r-1:0] instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic [15:0]  count_q, count_d;
  logic [15:0]  count_inc;

  assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  // Redirect beats stall in both states; a stalled halt keeps its word valid for decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (!bus.stall) begin
      case (state_q)
        RUN: begin
          instr_d    = bus.imem_readdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          count_d    = count_inc;
          if (bus.imem_readdata == HALT_WORD) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
        HALTED: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign halted          = (state_q == HALTED);
  assign fetch_count     = count_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage with a behavioural model of
// the fetch rules and a queue of expected IF/ID contents.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        halted;
  logic [15:0] fetch_count;
  logic        dbg_state;
  logic [15:0] imem [0:31];

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [4:0]  m_pc;
  logic [15:0] m_instr;
  logic [4:0]  m_ipc;
  logic        m_valid;
  logic        m_halted;
  logic [15:0] m_count;
  logic [20:0] exp_q[$];

  fetch_stage_if #(.n(16), .r(5)) bus ();

  fetch_stage #(.n(16), .r(5), .HALT_WORD(16'hFFFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .halted      (halted),
    .fetch_count (fetch_count),
    .dbg_state   (dbg_state)
  );

  assign bus.imem_readdata = imem[bus.imem_addr];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_halted = 1'b0; m_count = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [4:0] rpc);
    logic [15:0] w;
    if (rv) begin
      m_pc = rpc; m_valid = 1'b0; m_halted = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else begin
      w = imem[m_pc];
      m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      exp_q.push_back({m_pc, w});
      if (w == 16'hFFFF) m_halted = 1'b1;
      else m_pc = m_pc + 5'd1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [20:0] e;
    chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(m_pc));
    chk({tag, ".instr"}, 32'(bus.instr), 32'(m_instr));
    chk({tag, ".instr_pc"}, 32'(bus.instr_pc), 32'(m_ipc));
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(m_valid));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
    chk({tag, ".state"}, 32'(dbg_state), 32'(m_halted));
    chk({tag, ".count"}, 32'(fetch_count), 32'(m_count));
    if (m_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".sb"}, 32'({bus.instr_pc, bus.instr}), 32'(e));
    end
  endtask

  task automatic cycle(input string tag, input logic st, input logic rv, input logic [4:0] rpc);
    bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    @(posedge clk);
    model_step(st, rv, rpc);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    for (int i = 0; i < 32; i++) begin
      imem[i] = 16'($urandom_range(0, 16'hFFFE));
    end
    imem[0] = 16'h1111; imem[1] = 16'h2222; imem[2] = 16'h3333; imem[3] = 16'h4444;
    imem[31] = 16'hABCD;
    @(negedge clk);
    do_reset("reset");

    // Sequential fetch
    for (int i = 0; i < 4; i++) cycle("seq", 1'b0, 1'b0, 5'd0);
    chk("seq_instr4", 32'(bus.instr), 32'h4444);
    chk("seq_count4", 32'(fetch_count), 32'd4);

    // Stall after 2222
    do_reset("reset2");
    cycle("st_f", 1'b0, 1'b0, 5'd0);
    cycle("st_f", 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1'b1, 1'b0, 5'd0);
      chk("stall_instr", 32'(bus.instr), 32'h2222);
      chk("stall_addr", 32'(bus.imem_addr), 32'd2);
    end
    cycle("st_rel", 1'b0, 1'b0, 5'd0);
    chk("stall_release", 32'(bus.instr), 32'h3333);

    // Redirect overriding stall at pc=3
    cycle("redir", 1'b1, 1'b1, 5'd20);
    chk("redir_bubble", 32'(bus.instr_valid), 32'd0);
    chk("redir_addr", 32'(bus.imem_addr), 32'd20);
    cycle("redir_tgt", 1'b0, 1'b0, 5'd0);
    chk("redir_tgt_pc", 32'(bus.instr_pc), 32'd20);

    // Wrap-around
    cycle("wrap_r", 1'b0, 1'b1, 5'd31);
    cycle("wrap31", 1'b0, 1'b0, 5'd0);
    chk("wrap_abcd", 32'(bus.instr), 32'hABCD);
    cycle("wrap0", 1'b0, 1'b0, 5'd0);
    chk("wrap_pc0", 32'(bus.instr_pc), 32'd0);
    chk("wrap_1111", 32'(bus.instr), 32'h1111);

    // Halt and resume
    imem[2] = 16'hFFFF;
    cycle("halt_r", 1'b0, 1'b1, 5'd0);
    for (int i = 0; i < 3; i++) cycle("halt_f", 1'b0, 1'b0, 5'd0);
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_valid", 32'(bus.instr_valid), 32'd1);
    cycle("halt_stall", 1'b1, 1'b0, 5'd0);
    chk("halt_stall_valid", 32'(bus.instr_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      cycle("halt_idle", 1'b0, 1'b0, 5'd0);
      chk("halt_idle_valid", 32'(bus.instr_valid), 32'd0);
      chk("halt_idle_addr", 32'(bus.imem_addr), 32'd2);
    end
    cycle("resume_r", 1'b0, 1'b1, 5'd0);
    chk("resume_halted", 32'(halted), 32'd0);
    cycle("resume_f", 1'b0, 1'b0, 5'd0);
    chk("resume_instr", 32'(bus.instr), 32'h1111);

    // Reach HALTED with fetch_count=7, then pulse async reset between edges
    do_reset("reset3");
    for (int i = 0; i < 3; i++) cycle("h7a", 1'b0, 1'b0, 5'd0);
    cycle("h7r", 1'b0, 1'b1, 5'd0);
    for (int i = 0; i < 3; i++) cycle("h7b", 1'b0, 1'b0, 5'd0);
    cycle("h7r2", 1'b0, 1'b1, 5'd2);
    cycle("h7c", 1'b0, 1'b0, 5'd0);
    chk("h7_count", 32'(fetch_count), 32'd7);
    chk("h7_halted", 32'(halted), 32'd1);
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_halted", 32'(halted), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0, 5'd0);
    @(negedge clk);
    check_all("restart");
    chk("restart_pc", 32'(bus.instr_pc), 32'd0);

    // Randomized traffic with occasional halt words
    for (int i = 0; i < 32; i++) begin
      imem[i] = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
    end
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the 16-bit single-issue core. It owns the program counter and drives the address port of the 32-word instruction memory `imem`. `imem` is combinational: `addr` in, `readdata` out in the same cycle. The stage captures the returned word into an IF/ID pipeline register for the decode stage. It supports stall, redirect (branch/jump), halt detection on a reserved opcode word, and a saturating retired-fetch counter.

## Interface
- `n`, 16, instruction/data word width
- `r`, 5, imem address width (2**r words)
- `HALT_WORD`, 16'hFFFF, instruction encoding that halts fetch

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  decode not ready; hold PC and IF/ID register
- `redirect_valid`  in  1  branch/jump taken; load `redirect_pc`, squash IF/ID
- `redirect_pc`  in  r  redirect target word address
- `imem_addr`  out  r  word address to imem; always equals current PC
- `imem_readdata`  in  n  instruction word from imem, same cycle
- `instr`  out  n  IF/ID register: fetched instruction
- `instr_pc`  out  r  IF/ID register: address `instr` was fetched from
- `instr_valid`  out  1  IF/ID register holds a live instruction
- `halted`  out  1  stage is in HALTED state
- `fetch_count`  out  16  number of instructions latched valid into IF/ID, saturates at 16'hFFFF

## Operation
- States: RUN, HALTED. Reset state is RUN.
- `imem_addr` = `pc`, driven straight from the PC register with no combinational path from inputs.
- Priority each cycle is reset, then `redirect_valid`, then `stall`, then normal fetch.
- **RUN, redirect:**
  - `pc <= redirect_pc`; `instr_valid <= 0`.
  - `instr` and `instr_pc` hold their values.
  - Redirect overrides stall.
- **RUN, stall (no redirect):** PC, IF/ID register, state and counter all hold.
- **RUN, normal fetch, `imem_readdata != HALT_WORD`:**
  - `instr <= imem_readdata`; `instr_pc <= pc`; `instr_valid <= 1`.
  - `pc <= pc + 1`, modulo 2**r, so 31 wraps to 0.
  - `fetch_count` increments.
- **RUN, normal fetch, `imem_readdata == HALT_WORD`:**
  - The halt word is latched like any instruction: `instr_valid <= 1`, `instr_pc <= pc`, `fetch_count` increments.
  - `pc` does not increment.
  - State becomes HALTED.
- **HALTED, redirect:** `pc <= redirect_pc`; `instr_valid <= 0`; state becomes RUN. This is the only exit besides reset.
- **HALTED, stall:** everything holds, so the latched halt word is not lost while decode is stalled.
- **HALTED, no stall:** `instr_valid <= 0`. PC, `instr`, `instr_pc` and counter hold.
- `halted` = (state == HALTED), registered.
- `fetch_count` saturates at 16'hFFFF and never wraps.

## Timing
- Reset (asynchronous, takes effect immediately, independent of `clk`):
  - `pc` = 0, `imem_addr` = 0
  - `instr` = 0, `instr_pc` = 0, `instr_valid` = 0
  - `halted` = 0, `fetch_count` = 0, state = RUN
- First valid instruction (`instr` = imem[0], `instr_pc` = 0) appears after the first rising edge following reset deassertion with `stall` = 0.
- Fetch latency: 1 cycle from `imem_addr` to `instr`. Throughput: 1 instruction/cycle with no stall.
- Redirect penalty: the edge that samples `redirect_valid` produces a single bubble (`instr_valid` = 0). The target word is latched on the next edge.
- `halted` rises on the same edge that latches `HALT_WORD` into `instr`.
- Reset asserted mid-operation (any state, including during stall or redirect) returns all outputs to their reset values asynchronously. No state survives.
- All inputs are sampled only on rising `clk`. Outputs change only on rising `clk` or on reset assertion.

## Test plan
- **Sequential fetch:** imem[0..3] = 16'h1111, 16'h2222, 16'h3333, 16'h4444; release reset.
  - After edges 1–4, `instr` = 1111/2222/3333/4444 with `instr_pc` = 0..3 and `instr_valid` = 1.
  - `fetch_count` = 4.
- **Stall:** assert `stall` for 3 cycles after `instr` = 16'h2222.
  - `instr`, `instr_pc` = 1, `imem_addr` = 2 and `fetch_count` all hold.
  - On release, the next edge yields 16'h3333.
- **Redirect with simultaneous stall:** at `pc` = 3, assert `redirect_valid` = 1, `redirect_pc` = 5'd20, `stall` = 1.
  - Next edge: `instr_valid` = 0, `imem_addr` = 20.
  - Following edge: `instr` = imem[20], `instr_pc` = 20.
- **Wrap-around:** redirect to 31 with imem[31] = 16'hABCD, imem[0] = 16'h1111.
  - `instr` = ABCD with `instr_pc` = 31, then 16'h1111 with `instr_pc` = 0.
- **Halt and resume:** imem[2] = 16'hFFFF.
  - After latching it: `halted` = 1, `instr_valid` = 1 for exactly one cycle, then 0.
  - `imem_addr` stays at 2 for 5+ cycles.
  - Redirect to 0 clears `halted`; the next edge refetches imem[0].
- **Async reset mid-run:** pulse `reset` between clock edges while `fetch_count` = 7 and state is HALTED.
  - All outputs go to 0 and `halted` = 0 immediately, before the next `clk` edge.
  - Fetch restarts at address 0.
